// File: rtl/vector_to_angle_cordic.sv
// vector_to_angle_cordic
//   Converts a signed fixed-point (x, y) vector into its angle atan2(y, x)
//   and its gain-compensated magnitude. It uses iterative CORDIC in vectoring
//   mode and performs one micro-rotation per clock. The interface is a
//   start/busy/done handshake.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   conversion request, sampled only while idle
//   x_in       in   signed x component, Q16.16
//   y_in       in   signed y component, Q16.16
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse, results valid
//   angle_out  out  signed angle in radians, Q16.16, range (-pi, +pi]
//   mag_out    out  magnitude in Q16.16, CORDIC gain removed
//   zero_vec   out  result came from a (0, 0) input vector
module vector_to_angle_cordic #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ITER  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] angle_out,
  output logic        [WIDTH-1:0] mag_out,
  output logic                    zero_vec
);

  // Two guard bits absorb the CORDIC gain (~1.647) and the sqrt(2) growth.
  localparam int XW = WIDTH + 2;
  // The product is wide enough for the full x register times an 18-bit constant.
  localparam int PW = XW + 18;

  localparam logic signed [WIDTH-1:0] PI     = WIDTH'(205887);
  localparam logic signed [17:0]      K_INV  = 18'sd39797;  // 0.607253 in Q0.16
  localparam logic        [4:0]       LAST_I = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, ITERATE, FINISH} state_t;

  state_t                   state_q;
  logic signed [XW-1:0]     x_q, y_q;
  logic signed [WIDTH-1:0]  z_q;
  logic        [4:0]        cnt_q;
  logic                     zero_q;
  logic                     busy_q, done_q, zero_vec_q;
  logic signed [WIDTH-1:0]  angle_q;
  logic        [WIDTH-1:0]  mag_q;

  logic signed [XW-1:0]     x_pre_d, y_pre_d;
  logic signed [WIDTH-1:0]  z_pre_d;
  logic signed [XW-1:0]     x_sh, y_sh;
  logic signed [XW-1:0]     x_rot_d, y_rot_d;
  logic signed [WIDTH-1:0]  z_rot_d;
  logic signed [WIDTH-1:0]  atan_i;
  logic signed [PW-1:0]     x_ext, k_ext;
  logic        [WIDTH-1:0]  mag_d;

  // atan(2^-i) in Q16.16
  always_comb begin
    atan_i = '0;
    case (cnt_q)
      5'd0:  atan_i = WIDTH'(51472);
      5'd1:  atan_i = WIDTH'(30386);
      5'd2:  atan_i = WIDTH'(16055);
      5'd3:  atan_i = WIDTH'(8150);
      5'd4:  atan_i = WIDTH'(4091);
      5'd5:  atan_i = WIDTH'(2047);
      5'd6:  atan_i = WIDTH'(1024);
      5'd7:  atan_i = WIDTH'(512);
      5'd8:  atan_i = WIDTH'(256);
      5'd9:  atan_i = WIDTH'(128);
      5'd10: atan_i = WIDTH'(64);
      5'd11: atan_i = WIDTH'(32);
      5'd12: atan_i = WIDTH'(16);
      5'd13: atan_i = WIDTH'(8);
      5'd14: atan_i = WIDTH'(4);
      5'd15: atan_i = WIDTH'(2);
      default: atan_i = '0;
    endcase
  end

  always_comb begin
    // Left half-plane vectors are rotated by pi so CORDIC only sees x >= 0.
    // y == 0 with x < 0 takes the +pi branch, so that case never yields -pi.
    x_pre_d = XW'(x_in);
    y_pre_d = XW'(y_in);
    z_pre_d = '0;
    if (x_in[WIDTH-1]) begin
      x_pre_d = -XW'(x_in);
      y_pre_d = -XW'(y_in);
      z_pre_d = y_in[WIDTH-1] ? -PI : PI;
    end

    // Both shifts use the pre-edge register values.
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (!y_q[XW-1]) begin
      x_rot_d = x_q + y_sh;
      y_rot_d = y_q - x_sh;
      z_rot_d = z_q + atan_i;
    end else begin
      x_rot_d = x_q - y_sh;
      y_rot_d = y_q + x_sh;
      z_rot_d = z_q - atan_i;
    end

    x_ext = PW'(x_q);
    k_ext = PW'(K_INV);
    mag_d = WIDTH'((x_ext * k_ext) >>> FRAC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_vec_q <= 1'b0;
      angle_q    <= '0;
      mag_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x_pre_d;
            y_q     <= y_pre_d;
            z_q     <= z_pre_d;
            zero_q  <= (x_in == '0) && (y_in == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ITERATE;
          end
        end
        ITERATE: begin
          x_q   <= x_rot_d;
          y_q   <= y_rot_d;
          z_q   <= z_rot_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_I) state_q <= FINISH;
        end
        FINISH: begin
          // A zero vector has no defined angle, so both results are forced to 0.
          angle_q    <= zero_q ? '0 : z_q;
          mag_q      <= zero_q ? '0 : mag_d;
          zero_vec_q <= zero_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;
  assign zero_vec  = zero_vec_q;

endmodule

// File: tb/tb_vector_to_angle_cordic.sv
// Self-checking bench for vector_to_angle_cordic: a table of directed vectors
// with hand-computed angles/magnitudes, then sequences for reset, start while
// busy, back-to-back starts and input changes during a conversion.
module tb_vector_to_angle_cordic;

  logic               clock;
  logic               reset;
  logic               start;
  logic signed [31:0] x_in, y_in;
  logic               busy, done, zero_vec;
  logic signed [31:0] angle_out;
  logic        [31:0] mag_out;

  int errors = 0;
  int checks = 0;

  vector_to_angle_cordic #(.WIDTH(32), .FRAC(16), .ITER(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .zero_vec  (zero_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int ang;
    int ang_tol;
    int mag;
    int mag_tol;
    bit zv;
  } vec_t;

  vec_t vecs[11];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (iabs(act - exp) > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Drives start for exactly one sampling edge (E0) and checks that busy rises.
  task automatic launch(input int xv, input int yv);
    @(negedge clock);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1, 0);
  endtask

  // Counts edges until done is seen; gives up after 40 edges.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic do_conv(input int xv, input int yv, output int ang,
                         output int mag, output int zv, output int edges);
    launch(xv, yv);
    wait_done(edges);
    chk("done_latency", edges, 17, 0);
    ang = angle_out;
    mag = mag_out;
    zv  = int'(zero_vec);
    chk("busy_at_done", int'(busy), 0, 0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", int'(done), 0, 0);
  endtask

  initial begin
    int ang, mag, zv, edges, pulses, first_k, second_k;

    vecs[0]  = '{65536,       0,       0, 16, 65536,  81, 1'b0};
    vecs[1]  = '{0,       65536,  102944, 16, 65536,  81, 1'b0};
    vecs[2]  = '{0,      -65536, -102944, 16, 65536,  81, 1'b0};
    vecs[3]  = '{-65536,      0,  205887, 16, 65536,  81, 1'b0};
    vecs[4]  = '{-65536, -65536, -154415, 16, 92682, 100, 1'b0};
    vecs[5]  = '{-65536,  65536,  154415, 16, 92682, 100, 1'b0};
    vecs[6]  = '{57513,   31420,   32768, 16, 65536, 100, 1'b0};  // 0.5 rad
    vecs[7]  = '{-52504,  39221,  163840, 16, 65536, 100, 1'b0};  // 2.5 rad
    vecs[8]  = '{-27273, -59592, -131072, 16, 65536, 100, 1'b0};  // -2.0 rad
    vecs[9]  = '{0,           0,       0,  0,     0,   0, 1'b1};
    vecs[10] = '{65536,       0,       0, 16, 65536,  81, 1'b0};  // clears zero_vec

    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy",  int'(busy), 0, 0);
    chk("reset_done",  int'(done), 0, 0);
    chk("reset_zv",    int'(zero_vec), 0, 0);
    chk("reset_angle", angle_out, 0, 0);
    chk("reset_mag",   int'(mag_out), 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_conv(vecs[i].x, vecs[i].y, ang, mag, zv, edges);
      chk("angle", ang, vecs[i].ang, vecs[i].ang_tol);
      chk("mag",   mag, vecs[i].mag, vecs[i].mag_tol);
      chk("zero_vec", zv, int'(vecs[i].zv), 0);
      $display("vec %0d: x=%0d y=%0d angle=%0d mag=%0d zero_vec=%0d edges=%0d",
               i, vecs[i].x, vecs[i].y, ang, mag, zv, edges);
    end

    // Asynchronous reset in the middle of a conversion.
    do_conv(0, 65536, ang, mag, zv, edges);
    chk("pre_reset_angle", ang, 102944, 16);
    launch(65536, 65536);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_busy",  int'(busy), 0, 0);
    chk("async_reset_done",  int'(done), 0, 0);
    chk("async_reset_angle", angle_out, 0, 0);
    chk("async_reset_mag",   int'(mag_out), 0, 0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("no_done_after_reset", pulses, 0, 0);
    do_conv(65536, 0, ang, mag, zv, edges);
    chk("post_reset_angle", ang, 0, 16);
    chk("post_reset_mag",   mag, 65536, 81);
    $display("reset mid-conversion: angle=%0d mag=%0d edges=%0d", ang, mag, edges);

    // A start pulse during busy is ignored and is not queued.
    launch(65536, 0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("start_while_busy_pulses", pulses, 1, 0);
    chk("start_while_busy_idle", int'(busy), 0, 0);
    $display("start while busy: done pulses=%0d", pulses);

    // When start is held high, a new conversion begins in each done cycle.
    @(negedge clock);
    x_in  = 0;
    y_in  = 65536;
    start = 1'b1;
    pulses   = 0;
    first_k  = -1;
    second_k = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        pulses++;
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
        chk("b2b_angle", angle_out, 102944, 16);
      end
    end
    @(negedge clock);
    start = 1'b0;
    chk("b2b_pulses", pulses, 3, 0);
    chk("b2b_first", first_k, 17, 0);
    chk("b2b_gap", second_k - first_k, 18, 0);
    $display("back-to-back: pulses=%0d first=%0d second=%0d", pulses, first_k, second_k);
    wait_done(edges);
    chk("b2b_drain", int'(done), 1, 0);
    @(posedge clock);

    // Changes to the inputs after E0 do not affect the result.
    launch(65536, 65536);
    repeat (3) @(negedge clock);
    x_in = -65536;
    y_in = -3000;
    wait_done(edges);
    chk("mid_change_done", int'(done), 1, 0);
    chk("mid_change_angle", angle_out, 51472, 16);
    chk("mid_change_mag", int'(mag_out), 92682, 100);
    $display("input change mid-conversion: angle=%0d mag=%0d", angle_out, mag_out);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_to_angle_cordic.md
Name: vector_to_angle_cordic

Overview:
- Inverse of the sine/cosine calculator: takes a fixed-point (x, y) vector, e.g. (cosine, sine), and returns its angle atan2(y, x) and its magnitude.
- Iterative CORDIC in vectoring mode, one micro-rotation per clock, with a start/busy/done handshake.
- Sits beside the sine/cosine calculator in the Cyclone Cruiser datapath, so that an angle can be converted to a vector and back.

Parameters:
- WIDTH, 32: bit width of x_in, y_in, angle_out, mag_out (signed two's complement).
- FRAC, 16: fractional bits (Q16.16). The atan table and the pi constant are defined for FRAC=16 only.
- ITER, 16: number of CORDIC micro-rotations. Legal range 1..16.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  WIDTH  signed x component, Q16.16; |x_in| < 2^(WIDTH-3).
- y_in  in  WIDTH  signed y component, Q16.16; |y_in| < 2^(WIDTH-3).
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; result valid.
- angle_out  out  WIDTH  signed radians Q16.16, range (-pi, +pi].
- mag_out  out  WIDTH  unsigned-valued magnitude Q16.16, gain-compensated.
- zero_vec  out  1  result came from x_in=y_in=0.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state=IDLE.
  - busy, done, zero_vec = 0; angle_out = 0; mag_out = 0.
  - Iteration counter = 0; an in-flight conversion is discarded with no done pulse.
- State IDLE:
  - On an edge with start=1, capture x_in/y_in with preconditioning; busy=1; go to ITERATE with i=0. This is edge E0.
- Preconditioning, on the captured value (angle accumulator z):
  - x>=0: x, y unchanged, z = 0.
  - x<0 and y>=0: x=-x, y=-y, z=+PI where PI=205887.
  - x<0 and y<0: x=-x, y=-y, z=-PI.
- Datapath widths: the internal x/y registers are WIDTH+2 bits, sign-extended, to absorb the CORDIC gain (~1.647) and the sqrt(2) growth. z is WIDTH bits.
- State ITERATE: one micro-rotation per edge, E1..E_ITER, with arithmetic right shift:
  - If y>=0: x += y>>>i; y -= x>>>i; z += ATAN[i].
  - Else: x -= y>>>i; y += x>>>i; z -= ATAN[i].
  - The shifts use the values from before the edge.
  - i increments each edge. After the edge with i=ITER-1, go to FINISH.
- ATAN table, Q16.16, index 0..15: 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
- State FINISH, one edge (E_ITER+1):
  - angle_out = z.
  - mag_out = (x * 39797) >>> 16 (K=0.607253 in Q0.16), truncated to WIDTH.
  - zero_vec = (captured x_in==0 and y_in==0).
  - done=1, busy=0; go to IDLE.
- Zero-vector override: if zero_vec, angle_out=0 and mag_out=0 regardless of the iterations.
- done is high exactly one cycle, in the cycle after E_ITER+1. Latency from the start-sampling edge to done high is ITER+1 clock edges (17 at default).
- Outputs angle_out, mag_out and zero_vec hold their values until the next FINISH or a reset.
- start while busy=1 is ignored. It is not queued.
- start=1 in the same cycle that done=1 (state IDLE) is accepted, giving back-to-back conversions.
- Inputs are sampled only at E0; changes afterwards have no effect.
- Boundary values:
  - y=0, x<0 gives angle +PI, never -PI.
  - y=0, x>0 gives 0.
- Accuracy for ITER=16:
  - |angle error| <= 16 LSB.
  - mag error <= 0.1% + 16 LSB.

Test Plan:
- Reset: assert reset asynchronously mid-ITERATE (cycle 5 after start) → busy=0, done=0, angle_out=0 and mag_out=0 immediately; no done pulse follows; the next start works normally.
- Cardinal vectors:
  - (65536, 0) → angle 0±16, mag 65536.
  - (0, 65536) → angle 102944±16.
  - (0, -65536) → angle -102944±16.
  - Each gives done exactly 17 edges after start.
- Negative-x quadrants:
  - (-65536, 0) → angle +205887±16.
  - (-65536, -65536) → angle -154415±16, mag 92682±100.
  - (-65536, 65536) → angle +154415±16.
- Round-trip: feed the sine/cosine calculator outputs for angles 0.5, 2.5 and -2.0 rad (Q16.16) → angle_out within ±16 LSB of the original; mag 65536±100.
- Zero vector: (0, 0) → zero_vec=1, angle_out=0, mag_out=0, done pulses normally. The following (65536, 0) conversion clears zero_vec.
- Handshake:
  - Pulse start during busy → ignored, single done.
  - Hold start=1 continuously → back-to-back results with done every 18 cycles.
  - Change x_in mid-conversion → result unaffected.
